// File: rtl/sram_port_arbiter.sv
// Two-port arbiter and fixed-length cycle sequencer for an async 8-bit SRAM.
// Port A has priority; port B is forced through after B_STARVE_MAX A grants.
module sram_port_arbiter #(
  parameter int ADDR_W        = 21,
  parameter int ACCESS_CYCLES = 2,
  parameter int B_STARVE_MAX  = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic              a_ack,
  output logic [7:0]        a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic              b_ack,
  output logic [7:0]        b_rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic [7:0]        sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [7:0]        sram_dq_i,
  output logic              sram_nce,
  output logic              sram_noe,
  output logic              sram_nwe
);

  localparam int SW = $clog2(B_STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t        state;
  logic          sel_b;
  logic          we_q;
  logic [3:0]    cnt;
  logic [SW-1:0] starve_cnt;
  logic          starved;
  logic          pick_b;
  logic          any_req;

  assign starved = (starve_cnt == SW'(B_STARVE_MAX));
  assign pick_b  = b_req & (~a_req | starved);
  assign any_req = a_req | b_req;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= IDLE;
      sel_b      <= 1'b0;
      we_q       <= 1'b0;
      cnt        <= '0;
      starve_cnt <= '0;
      sram_a     <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_nce   <= 1'b1;
      sram_noe   <= 1'b1;
      sram_nwe   <= 1'b1;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // B losing a grant to A is the only way the count grows
          if (!b_req || pick_b)
            starve_cnt <= '0;
          else if (!starved)
            starve_cnt <= starve_cnt + SW'(1);
          if (any_req) begin
            state      <= SETUP;
            sel_b      <= pick_b;
            we_q       <= pick_b ? b_we : a_we;
            sram_a     <= pick_b ? b_addr : a_addr;
            sram_dq_o  <= pick_b ? b_wdata : a_wdata;
            sram_dq_oe <= pick_b ? b_we : a_we;
            sram_nce   <= 1'b0;
          end
        end
        SETUP: begin
          state    <= STROBE;
          cnt      <= 4'(ACCESS_CYCLES - 1);
          sram_noe <= we_q;
          sram_nwe <= ~we_q;
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            state    <= HOLD;
            sram_noe <= 1'b1;
            sram_nwe <= 1'b1;
            sram_nce <= 1'b1;
            a_ack    <= ~sel_b;
            b_ack    <= sel_b;
            if (!we_q && sel_b)
              b_rdata <= sram_dq_i;
            if (!we_q && !sel_b)
              a_rdata <= sram_dq_i;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          // DQ stays driven through HOLD for write hold time
          state      <= IDLE;
          a_ack      <= 1'b0;
          b_ack      <= 1'b0;
          sram_dq_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM model, ack scoreboard, timing checks.
// Extra instances cover the ACCESS_CYCLES = 1 and 15 builds.
module tb_sram_port_arbiter;

  logic        clk_sys;
  logic        reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [20:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [7:0]  a_rdata, b_rdata;
  logic [20:0] sram_a;
  logic [7:0]  sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_nce, sram_noe, sram_nwe;

  logic        x1_req, x1_ack, x1_back, x1_oe, x1_nce, x1_noe, x1_nwe;
  logic [7:0]  x1_rdata, x1_brdata, x1_dqo, x1_dqi;
  logic [20:0] x1_a;
  logic        x15_req, x15_ack, x15_back, x15_oe, x15_nce, x15_noe, x15_nwe;
  logic [7:0]  x15_rdata, x15_brdata, x15_dqo, x15_dqi;
  logic [20:0] x15_a;

  logic [7:0]  mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [7:0]  pre_data;

  typedef struct {
    logic       port;
    logic [7:0] rd;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errs   = 0;
  logic [7:0] exp_a = 8'h00;
  logic [7:0] exp_b = 8'h00;

  sram_port_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_nce(sram_nce), .sram_noe(sram_noe),
    .sram_nwe(sram_nwe)
  );

  sram_port_arbiter #(.ACCESS_CYCLES(1)) dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .a_req(x1_req), .a_we(1'b0), .a_addr(21'h00ABC), .a_wdata(8'h00),
    .a_ack(x1_ack), .a_rdata(x1_rdata),
    .b_req(1'b0), .b_we(1'b0), .b_addr(21'h0), .b_wdata(8'h00),
    .b_ack(x1_back), .b_rdata(x1_brdata),
    .sram_a(x1_a), .sram_dq_o(x1_dqo), .sram_dq_oe(x1_oe),
    .sram_dq_i(x1_dqi), .sram_nce(x1_nce), .sram_noe(x1_noe),
    .sram_nwe(x1_nwe)
  );

  sram_port_arbiter #(.ACCESS_CYCLES(15)) dut15 (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .a_req(x15_req), .a_we(1'b0), .a_addr(21'h00ABC), .a_wdata(8'h00),
    .a_ack(x15_ack), .a_rdata(x15_rdata),
    .b_req(1'b0), .b_we(1'b0), .b_addr(21'h0), .b_wdata(8'h00),
    .b_ack(x15_back), .b_rdata(x15_brdata),
    .sram_a(x15_a), .sram_dq_o(x15_dqo), .sram_dq_oe(x15_oe),
    .sram_dq_i(x15_dqi), .sram_nce(x15_nce), .sram_noe(x15_noe),
    .sram_nwe(x15_nwe)
  );

  assign sram_dq_i = mem[sram_a[11:0]];
  assign x1_dqi    = x1_a[7:0] ^ 8'h5A;
  assign x15_dqi   = x15_a[7:0] ^ 8'h5A;

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (pre_en)
      mem[pre_addr] <= pre_data;
    else if (!sram_nce && !sram_nwe)
      mem[sram_a[11:0]] <= sram_dq_o;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    exp_t e;
    chk("ack_excl", 32'(a_ack & b_ack), 0);
    chk("strobe_excl", 32'(!sram_noe && !sram_nwe), 0);
    chk("oe_excl", 32'(sram_dq_oe && !sram_noe), 0);
    if (a_ack || b_ack) begin
      chk("sb_depth", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_port", 32'(b_ack), 32'(e.port));
        chk("sb_rdata", b_ack ? b_rdata : a_rdata, e.rd);
      end
    end
  end

  // Called in an IDLE cycle; returns in the next IDLE cycle.
  task automatic access(input logic pb, input logic we,
                        input logic [20:0] ad, input logic [7:0] wd,
                        input logic [7:0] rd);
    exp_t e;
    if (pb) begin
      b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd;
      if (!we) exp_b = rd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
      if (!we) exp_a = rd;
    end
    e.port = pb;
    e.rd   = pb ? exp_b : exp_a;
    sb.push_back(e);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_sys);
      if (k == 1) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
      chk("nce", 32'(sram_nce), 32'(k > 3));
      chk("noe", 32'(sram_noe), 32'(!(!we && k >= 2 && k <= 3)));
      chk("nwe", 32'(sram_nwe), 32'(!(we && k >= 2 && k <= 3)));
      chk("dqoe", 32'(sram_dq_oe), 32'(we));
      chk("addr", 32'(sram_a), 32'(ad));
      if (we) chk("dqo", 32'(sram_dq_o), 32'(wd));
      chk("aack", 32'(a_ack), 32'(!pb && k == 4));
      chk("back", 32'(b_ack), 32'(pb && k == 4));
    end
    @(negedge clk_sys);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_cyc, b_cyc, n1, n15, c1, c15, na;
    logic nce6;
    logic [20:0] a6;
    int seq[$];

    reset_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    x1_req = 0; x15_req = 0;
    pre_en = 1'b1; pre_addr = 12'h345; pre_data = 8'hA5;
    repeat (3) @(negedge clk_sys);
    pre_en = 1'b0;

    chk("rst_nce", 32'(sram_nce), 1);
    chk("rst_noe", 32'(sram_noe), 1);
    chk("rst_nwe", 32'(sram_nwe), 1);
    chk("rst_dqoe", 32'(sram_dq_oe), 0);
    chk("rst_addr", 32'(sram_a), 0);
    chk("rst_dqo", 32'(sram_dq_o), 0);
    chk("rst_acks", 32'({a_ack, b_ack}), 0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    access(1'b0, 1'b0, 21'h12345, 8'h00, 8'hA5);
    access(1'b1, 1'b1, 21'h000FF, 8'h3C, 8'h00);
    chk("mem_ff", 32'(mem[12'h0FF]), 32'h3C);
    chk("b_rdata_keep", 32'(b_rdata), 0);

    // Collision: A reads 0xFF, B reads 0x12345
    a_req = 1; a_we = 0; a_addr = 21'h000FF;
    b_req = 1; b_we = 0; b_addr = 21'h12345;
    exp_a = 8'h3C; exp_b = 8'hA5;
    sb.push_back('{1'b0, 8'h3C});
    sb.push_back('{1'b1, 8'hA5});
    a_cyc = -1; b_cyc = -1; nce6 = 1'b1; a6 = '0;
    for (int k = 1; k <= 20 && b_cyc < 0; k++) begin
      @(negedge clk_sys);
      if (a_ack) begin a_cyc = k; a_req = 0; end
      if (b_ack) begin b_cyc = k; b_req = 0; end
      if (k == 6) begin nce6 = sram_nce; a6 = sram_a; end
    end
    chk("col_a_cyc", a_cyc, 4);
    chk("col_b_cyc", b_cyc, 9);
    chk("col_b_nce6", 32'(nce6), 0);
    chk("col_b_addr6", 32'(a6), 32'h12345);
    a_req = 0; b_req = 0;
    @(negedge clk_sys);

    // Starvation: A saturates the bus while B waits
    a_req = 1; a_we = 0; a_addr = 21'h12345;
    b_req = 1; b_we = 0; b_addr = 21'h000FF;
    exp_a = 8'hA5; exp_b = 8'h3C;
    for (int i = 0; i < 11; i++)
      sb.push_back('{(i == 8), (i == 8) ? 8'h3C : 8'hA5});
    for (int k = 0; k < 150 && seq.size() < 11; k++) begin
      @(negedge clk_sys);
      if (a_ack) seq.push_back(0);
      if (b_ack) begin seq.push_back(1); b_req = 0; end
      if (seq.size() == 11) a_req = 0;
    end
    a_req = 0; b_req = 0;
    na = 0;
    while (na < seq.size() && seq[na] == 0) na++;
    chk("starve_len", seq.size(), 11);
    chk("starve_a_first", na, 8);
    if (seq.size() == 11) begin
      chk("starve_b", seq[8], 1);
      chk("starve_resume", seq[9] + seq[10], 0);
    end
    @(negedge clk_sys);

    // Reset during the second STROBE cycle of an A write
    a_req = 1; a_we = 1; a_addr = 21'h00100; a_wdata = 8'h77;
    @(negedge clk_sys);
    a_req = 0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("rw_pre_nwe", 32'(sram_nwe), 0);
    reset_n = 1'b0;
    @(negedge clk_sys);
    chk("rw_nce", 32'(sram_nce), 1);
    chk("rw_noe", 32'(sram_noe), 1);
    chk("rw_nwe", 32'(sram_nwe), 1);
    chk("rw_dqoe", 32'(sram_dq_oe), 0);
    chk("rw_acks", 32'({a_ack, b_ack}), 0);
    chk("rw_rdata", 32'({a_rdata, b_rdata}), 0);
    exp_a = 8'h00; exp_b = 8'h00;
    reset_n = 1'b1;
    @(negedge clk_sys);
    access(1'b0, 1'b0, 21'h000FF, 8'h00, 8'h3C);

    // ACCESS_CYCLES = 1 and 15 builds
    x1_req = 1; x15_req = 1;
    n1 = 0; n15 = 0; c1 = -1; c15 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_sys);
      if (k == 1) begin x1_req = 0; x15_req = 0; end
      if (!x1_noe) n1++;
      if (!x15_noe) n15++;
      if (x1_ack) c1 = k;
      if (x15_ack) c15 = k;
    end
    chk("ac1_noe", n1, 1);
    chk("ac1_ack", c1, 3);
    chk("ac1_rdata", 32'(x1_rdata), 32'hE6);
    chk("ac15_noe", n15, 15);
    chk("ac15_ack", c15, 17);
    chk("ac15_rdata", 32'(x15_rdata), 32'hE6);

    chk("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-port arbiter and cycle sequencer for the single external 8-bit asynchronous SRAM bus (21-bit address, active-low nCE/nOE/nWE). It shares the SRAM between the Next core memory port (port A, priority) and the HPS image/ROM loader port (port B). Each granted request becomes one fixed-length SRAM read or write cycle. The block sits between the core/loader and the SRAM pin driver, in the `clk_sys` (28 MHz) domain.

## Interface
Parameters:
- `ADDR_W`, 21: SRAM address width.
- `ACCESS_CYCLES`, 2: number of clock cycles the nOE/nWE strobe is held low. Legal range is 1..15.
- `B_STARVE_MAX`, 8: number of consecutive A grants allowed while B waits, before B is forced through.

Ports:
- `clk_sys` in 1: system clock. This is the only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `a_req` in 1: port A request level.
- `a_we` in 1: port A write (1) or read (0).
- `a_addr` in ADDR_W: port A address.
- `a_wdata` in 8: port A write data.
- `a_ack` out 1: one-cycle completion pulse to port A.
- `a_rdata` out 8: port A read data register.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: same as the port A set, for port B.
- `sram_a` out ADDR_W: SRAM address.
- `sram_dq_o` out 8: SRAM write data.
- `sram_dq_oe` out 1: 1 = drive the DQ pins.
- `sram_dq_i` in 8: SRAM read data.
- `sram_nce`, `sram_noe`, `sram_nwe` out 1: active-low SRAM strobes.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- **IDLE**
  - If `a_req` or `b_req` is high: choose the winner, latch its `we`, `addr` and `wdata`, then go to SETUP.
  - Otherwise stay in IDLE.
- **Arbitration**
  - A wins when both request.
  - Exception: B wins when `starve_cnt` == `B_STARVE_MAX`.
- **starve_cnt**
  - Increments on each A grant made while `b_req` is high.
  - Clears on a B grant, or in any IDLE cycle with `b_req` low.
  - Saturates at `B_STARVE_MAX`.
- **SETUP** (1 cycle)
  - `sram_a` = latched address; `sram_nce` = 0.
  - On a write: `sram_dq_oe` = 1 and `sram_dq_o` = latched data.
  - Then go to STROBE and load the strobe counter with `ACCESS_CYCLES`-1.
- **STROBE** (`ACCESS_CYCLES` cycles)
  - `sram_noe` = 0 for a read; `sram_nwe` = 0 for a write.
  - In the last STROBE cycle, a read registers `sram_dq_i` into the winner's `rdata`.
  - Then go to HOLD.
- **HOLD** (1 cycle)
  - `sram_noe` = `sram_nwe` = 1 and `sram_nce` = 1.
  - `sram_dq_oe` stays at its SETUP value; write data is held for one more cycle.
  - The winner's ack = 1.
  - Then go to IDLE unconditionally.
- Request inputs are sampled only in IDLE. Changes to `addr`, `wdata` or `we` after the grant have no effect.
- A requester may assert req again in the cycle after its ack (back-to-back access).
- `rdata` of each port holds its last read value until that port's next read completes. Writes never change `rdata`.
- Only one of `a_ack`/`b_ack` is ever high, and only in HOLD.
- Strobe exclusivity: `sram_noe` and `sram_nwe` are never both 0. `sram_dq_oe` is never 1 while `sram_noe` = 0.

## Timing
- All outputs are registered.
- Reset values (`reset_n` = 0 at a clock edge):
  - State = IDLE.
  - `sram_a` = 0, `sram_dq_o` = 0, `sram_dq_oe` = 0.
  - `sram_nce` = `sram_noe` = `sram_nwe` = 1.
  - `a_ack` = `b_ack` = 0, `a_rdata` = `b_rdata` = 0, `starve_cnt` = 0.
- Reset asserted mid-access: the cycle is abandoned at the next edge. No ack is issued; strobes go high and DQ is released.
- Latency: req sampled in IDLE at cycle 0 → SETUP at cycle 1 → STROBE at cycles 2..`ACCESS_CYCLES`+1 → HOLD/ack at cycle `ACCESS_CYCLES`+2.
- One access occupies `ACCESS_CYCLES`+3 cycles including IDLE. With the defaults: ack at cycle 4, throughput 1 access per 5 cycles.
- Read data is valid on `x_rdata` in the ack cycle.

## Test plan
- **Single read, A**: preload SRAM model [0x12345] = 0xA5; A reads 0x12345.
  - Required: `sram_nce` low at cycles 1–3, `sram_noe` low at cycles 2–3, `a_ack` at cycle 4 with `a_rdata` = 0xA5.
  - `b_ack` stays 0 and `sram_dq_oe` stays 0 throughout.
- **Single write, B**: B writes 0x3C to 0x000FF.
  - Required: `sram_dq_oe` = 1 at cycles 1–4, `sram_nwe` low only at cycles 2–3, `b_ack` at cycle 4.
  - Model [0xFF] = 0x3C; `b_rdata` unchanged.
- **Collision**: A and B both request in the same IDLE cycle.
  - Required: A is served first (`a_ack` at cycle 4). B is granted at cycle 6 (`b_ack` at cycle 9) when A drops its request after its ack.
- **Starvation**: A requests continuously back-to-back while B holds `b_req`; `B_STARVE_MAX` = 8.
  - Required: exactly 8 `a_ack` pulses, then one `b_ack`, then A resumes.
- **Reset mid-write**: `reset_n` = 0 during the second STROBE cycle.
  - Required: on the next edge, strobes = 1, `sram_dq_oe` = 0, no ack, FSM in IDLE.
  - A request issued after reset completes normally.
- **ACCESS_CYCLES** = 1 and = 15 builds: `sram_noe` low for exactly 1 and exactly 15 cycles; ack at cycle 3 and cycle 17 respectively.
